// File: rtl/threshold_dac_spi.sv
// Threshold DAC responder: accepts a 16-bit code, ships it as a 24-bit SPI frame
// (CPOL=0, CPHA=0), then holds ready low until the DAC output has settled.
module threshold_dac_spi #(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  CMD_BYTE      = 8'h00,
    parameter logic [15:0] INIT_CODE     = 16'h0000
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic [15:0] threshold_i,
    input  logic        threshold_wre_i,
    output logic        threshold_rdy_o,
    output logic        drop_o,
    output logic [15:0] dac_code_o,
    output logic        dac_sclk_o,
    output logic        dac_cs_n_o,
    output logic        dac_mosi_o
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned CODE_W  = 16;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned CNT_MAX = (CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SHIFT,
        S_CS_HOLD,
        S_SETTLE
    } state_t;

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt;

    logic                 start_c;
    logic [FRAME_W-1:0]   frame_c;

    // The INIT frame is launched unconditionally; otherwise a write in IDLE starts one.
    assign start_c = (state == S_INIT) || ((state == S_IDLE) && threshold_wre_i);
    assign frame_c = {CMD_BYTE, (state == S_INIT) ? INIT_CODE : threshold_i};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= S_INIT;
            shreg           <= '0;
            bit_cnt         <= '0;
            cnt             <= '0;
            threshold_rdy_o <= 1'b0;
            drop_o          <= 1'b0;
            dac_code_o      <= '0;
            dac_sclk_o      <= 1'b0;
            dac_cs_n_o      <= 1'b1;
            dac_mosi_o      <= 1'b0;
        end else begin
            drop_o <= threshold_wre_i && !threshold_rdy_o;

            case (state)
                S_INIT, S_IDLE: begin
                    if (start_c) begin
                        shreg           <= frame_c;
                        dac_mosi_o      <= frame_c[FRAME_W-1];
                        dac_cs_n_o      <= 1'b0;
                        dac_sclk_o      <= 1'b0;
                        threshold_rdy_o <= 1'b0;
                        bit_cnt         <= BIT_W'(FRAME_W - 1);
                        cnt             <= '0;
                        state           <= S_SHIFT;
                    end
                end

                // Each bit: CLK_DIV cycles low then CLK_DIV high; MOSI moves only on the fall.
                S_SHIFT: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!dac_sclk_o) begin
                            dac_sclk_o <= 1'b1;
                        end else begin
                            dac_sclk_o <= 1'b0;
                            if (bit_cnt == '0) begin
                                state <= S_CS_HOLD;
                            end else begin
                                bit_cnt    <= bit_cnt - BIT_W'(1);
                                dac_mosi_o <= shreg[bit_cnt - BIT_W'(1)];
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_CS_HOLD: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt        <= '0;
                        dac_cs_n_o <= 1'b1;
                        state      <= S_SETTLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt             <= '0;
                        threshold_rdy_o <= 1'b1;
                        dac_code_o      <= shreg[CODE_W-1:0];
                        state           <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule
